// File: rtl/lsu_defs_pkg.sv
// Shared definitions for the load/store unit.
// Holds funct3 encodings, FSM state codes and the request legality check.
package lsu_defs_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } lsu_state_t;

  // Unsigned loads exist only for reads; anything else is illegal for both directions.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input int unsigned words);
    logic legal;
    logic misal;
    legal = 1'b0;
    misal = 1'b0;
    case (f3)
      F3_B:  legal = 1'b1;
      F3_BU: legal = ~we;
      F3_H: begin
        legal = 1'b1;
        misal = addr[0];
      end
      F3_HU: begin
        legal = ~we;
        misal = addr[0];
      end
      F3_W: begin
        legal = 1'b1;
        misal = |addr[1:0];
      end
      default: legal = 1'b0;
    endcase
    return ~legal | misal | ({2'b00, addr[31:2]} >= words);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extracts and extends load data, and merges
// store data into an existing word for read-modify-write.
module lsu_lane
  import lsu_defs_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask;

  always_comb begin
    sh         = {offset, 3'b000};
    b          = 8'(word >> sh);
    h          = offset[1] ? word[31:16] : word[15:0];
    bmask      = 32'h0000_00FF << sh;
    load_val   = word;
    store_word = word;
    case (funct3)
      F3_B: begin
        load_val   = {{24{b[7]}}, b};
        store_word = (word & ~bmask) | ({24'h0, wdata[7:0]} << sh);
      end
      F3_H: begin
        load_val   = {{16{h[15]}}, h};
        store_word = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      F3_W:    store_word = wdata;
      F3_BU:   load_val   = {24'h0, b};
      F3_HU:   load_val   = {16'h0, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32I load/store at a time, word-granular
// memory accesses with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_defs_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  lsu_state_t  state;
  logic        we_q;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        accept_err;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  assign accept_err = req_error(req_we, req_funct3, req_addr, MEM_WORDS);

  // Gating by reset keeps an in-flight write from landing on the reset edge.
  assign mem_we = we_q & ~reset;

  lsu_lane u_lane (
    .word       (mem_dout),
    .offset     (off_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_val   (lane_load),
    .store_word (lane_store)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      st_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          we_q      <= 1'b0;
          if (req_valid) begin
            st_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (accept_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              // Full-word stores skip the read and write during ACCESS.
              if (req_we && req_funct3 == F3_W) begin
                we_q    <= 1'b1;
                mem_din <= req_wdata;
              end
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          we_q <= 1'b0;
          if (!st_q || f3_q == F3_W) begin
            rsp_rdata <= st_q ? '0 : lane_load;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            mem_din <= lane_store;
            we_q    <= 1'b1;
            state   <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          we_q      <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
